// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl: single-entry issue buffer with a muldiv register scoreboard
// and a taken-branch redirect/flush sequencer in front of the exec stage.
module exec_issue_ctrl #(
    parameter int MAX_PENDING  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_accept_o,
    output logic        fetch_branch_o,
    output logic [31:0] fetch_branch_pc_o,
    input  logic        hold_i,
    output logic        opcode_valid_o,
    output logic [31:0] opcode_opcode_o,
    output logic [31:0] opcode_pc_o,
    output logic [4:0]  opcode_rd_idx_o,
    output logic [4:0]  opcode_ra_idx_o,
    output logic [4:0]  opcode_rb_idx_o,
    input  logic        branch_d_request_i,
    input  logic [31:0] branch_d_pc_i,
    output logic        muldiv_valid_o,
    input  logic        muldiv_ready_i,
    input  logic        muldiv_done_i,
    input  logic [4:0]  muldiv_done_rd_i,
    output logic        stall_o
);
    typedef enum logic {RUN, FLUSH} state_e;

    state_e      state_q, state_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] sb_q, sb_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [4:0]  rd, ra, rb;
    logic        is_long, hazard, can_issue, capture, dec;
    logic [31:0] set_mask, clr_mask;

    assign opcode_opcode_o = buf_valid_q ? buf_instr_q : '0;
    assign opcode_pc_o     = buf_valid_q ? buf_pc_q : '0;
    assign rd              = opcode_opcode_o[11:7];
    assign ra              = opcode_opcode_o[19:15];
    assign rb              = opcode_opcode_o[24:20];
    assign opcode_rd_idx_o = rd;
    assign opcode_ra_idx_o = ra;
    assign opcode_rb_idx_o = rb;

    assign is_long = buf_valid_q && opcode_opcode_o[6:0] == 7'b0110011
                     && opcode_opcode_o[31:25] == 7'b0000001;
    // x0 is never tracked, so a zero index can never raise a hazard
    assign hazard = buf_valid_q && ((ra != 5'd0 && sb_q[ra]) || (rb != 5'd0 && sb_q[rb])
                                    || (rd != 5'd0 && sb_q[rd]));
    assign can_issue = buf_valid_q && !hazard && !hold_i
                       && (!is_long || (muldiv_ready_i && cnt_q < 3'(MAX_PENDING)));

    assign opcode_valid_o = can_issue && state_q == RUN;
    assign muldiv_valid_o = opcode_valid_o && is_long;
    assign stall_o        = buf_valid_q && !opcode_valid_o;
    assign fetch_accept_o = state_q == FLUSH
                            || (!hold_i && (!buf_valid_q || opcode_valid_o) && !branch_d_request_i);
    assign capture        = fetch_accept_o && fetch_valid_i && state_q == RUN;

    assign fetch_branch_o    = redirect_q;
    assign fetch_branch_pc_o = redirect_pc_q;

    // set is applied after clear so a same-cycle set/clear of one register keeps it busy
    assign set_mask = (muldiv_valid_o && rd != 5'd0) ? (32'd1 << rd) : '0;
    assign clr_mask = muldiv_done_i ? (32'd1 << muldiv_done_rd_i) : '0;
    assign sb_d     = (sb_q & ~clr_mask) | set_mask;
    assign dec      = muldiv_done_i && cnt_q != 3'd0;
    assign cnt_d    = cnt_q + {2'b0, muldiv_valid_o} - {2'b0, dec};

    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        buf_valid_d   = buf_valid_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (state_q == RUN) begin
            if (opcode_valid_o && branch_d_request_i) begin
                state_d       = FLUSH;
                flush_d       = 3'(FLUSH_CYCLES);
                buf_valid_d   = 1'b0;
                redirect_d    = 1'b1;
                redirect_pc_d = branch_d_pc_i;
            end else if (capture) begin
                buf_valid_d = 1'b1;
                buf_instr_d = fetch_instr_i;
                buf_pc_d    = fetch_pc_i;
            end else if (opcode_valid_o) begin
                buf_valid_d = 1'b0;
            end
        end else if (!hold_i) begin
            flush_d = flush_q - 3'd1;
            state_d = flush_q <= 3'd1 ? RUN : FLUSH;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            flush_q       <= '0;
            buf_valid_q   <= 1'b0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            sb_q          <= '0;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            buf_valid_q   <= buf_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            sb_q          <= sb_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end
endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb_exec_issue_ctrl: directed per-cycle vector table plus a reset-during-flush
// sequence; inputs change on the falling edge and outputs are sampled 1ns later.
module tb_exec_issue_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_instr_i = '0;
    logic [31:0] fetch_pc_i = '0;
    logic        fetch_accept_o, fetch_branch_o;
    logic [31:0] fetch_branch_pc_o;
    logic        hold_i = 1'b0;
    logic        opcode_valid_o;
    logic [31:0] opcode_opcode_o, opcode_pc_o;
    logic [4:0]  opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o;
    logic        branch_d_request_i = 1'b0;
    logic [31:0] branch_d_pc_i = '0;
    logic        muldiv_valid_o;
    logic        muldiv_ready_i = 1'b1;
    logic        muldiv_done_i = 1'b0;
    logic [4:0]  muldiv_done_rd_i = '0;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    exec_issue_ctrl #(.MAX_PENDING(2), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .fetch_accept_o(fetch_accept_o), .fetch_branch_o(fetch_branch_o),
        .fetch_branch_pc_o(fetch_branch_pc_o), .hold_i(hold_i),
        .opcode_valid_o(opcode_valid_o), .opcode_opcode_o(opcode_opcode_o),
        .opcode_pc_o(opcode_pc_o), .opcode_rd_idx_o(opcode_rd_idx_o),
        .opcode_ra_idx_o(opcode_ra_idx_o), .opcode_rb_idx_o(opcode_rb_idx_o),
        .branch_d_request_i(branch_d_request_i), .branch_d_pc_i(branch_d_pc_i),
        .muldiv_valid_o(muldiv_valid_o), .muldiv_ready_i(muldiv_ready_i),
        .muldiv_done_i(muldiv_done_i), .muldiv_done_rd_i(muldiv_done_rd_i),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [31:0] ADD1 = {7'd0, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33};
    localparam logic [31:0] ADD8 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd8, 7'h33};
    localparam logic [31:0] MUL5 = {7'd1, 5'd7, 5'd6, 3'd0, 5'd5, 7'h33};
    localparam logic [31:0] MUL9 = {7'd1, 5'd7, 5'd6, 3'd0, 5'd9, 7'h33};
    localparam logic [31:0] M1   = {7'd1, 5'd12, 5'd11, 3'd0, 5'd10, 7'h33};
    localparam logic [31:0] M2   = {7'd1, 5'd15, 5'd14, 3'd0, 5'd13, 7'h33};
    localparam logic [31:0] M3   = {7'd1, 5'd18, 5'd17, 3'd0, 5'd16, 7'h33};
    localparam logic [31:0] MA   = {7'd1, 5'd22, 5'd21, 3'd0, 5'd20, 7'h33};
    localparam logic [31:0] MB   = {7'd1, 5'd25, 5'd24, 3'd0, 5'd23, 7'h33};
    localparam logic [31:0] MC   = {7'd1, 5'd28, 5'd27, 3'd0, 5'd26, 7'h33};
    localparam logic [31:0] BEQ  = 32'h0000_0063;

    // ctl = {fetch_valid, hold, branch_request, muldiv_ready, muldiv_done}
    // exp = {opcode_valid, stall, muldiv_valid, fetch_accept, fetch_branch}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] instr, pc, bpc;
        logic [4:0]  drd;
        logic [4:0]  exp;
        logic [31:0] e_pc, e_bpc;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] instr, pc, bpc,
                                input logic [4:0] drd, input logic [4:0] exp,
                                input logic [31:0] e_pc, e_bpc);
        vec_t v;
        v.ctl = ctl; v.instr = instr; v.pc = pc; v.bpc = bpc; v.drd = drd;
        v.exp = exp; v.e_pc = e_pc; v.e_bpc = e_bpc;
        return v;
    endfunction

    task automatic chk(input int idx, input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row %0d %s got %h exp %h", idx, nm, got, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input int idx);
        @(negedge clk_i);
        {fetch_valid_i, hold_i, branch_d_request_i, muldiv_ready_i, muldiv_done_i} = v.ctl;
        fetch_instr_i    = v.instr;
        fetch_pc_i       = v.pc;
        branch_d_pc_i    = v.bpc;
        muldiv_done_rd_i = v.drd;
        #1;
        chk(idx, "opcode_valid", {31'd0, opcode_valid_o}, {31'd0, v.exp[4]});
        chk(idx, "stall", {31'd0, stall_o}, {31'd0, v.exp[3]});
        chk(idx, "muldiv_valid", {31'd0, muldiv_valid_o}, {31'd0, v.exp[2]});
        chk(idx, "fetch_accept", {31'd0, fetch_accept_o}, {31'd0, v.exp[1]});
        chk(idx, "fetch_branch", {31'd0, fetch_branch_o}, {31'd0, v.exp[0]});
        chk(idx, "opcode_pc", opcode_pc_o, v.e_pc);
        chk(idx, "branch_pc", fetch_branch_pc_o, v.e_bpc);
    endtask

    vec_t tbl[34];

    initial begin
        tbl[0]  = mk(5'b10010, ADD1, 32'h100, 32'h0, 5'd0,  5'b00010, 32'h0,   32'h0);
        tbl[1]  = mk(5'b10010, ADD1, 32'h104, 32'h0, 5'd0,  5'b10010, 32'h100, 32'h0);
        tbl[2]  = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b10010, 32'h104, 32'h0);
        tbl[3]  = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b00010, 32'h0,   32'h0);
        tbl[4]  = mk(5'b10010, MUL5, 32'h110, 32'h0, 5'd0,  5'b00010, 32'h0,   32'h0);
        tbl[5]  = mk(5'b10010, ADD8, 32'h114, 32'h0, 5'd0,  5'b10110, 32'h110, 32'h0);
        tbl[6]  = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b01000, 32'h114, 32'h0);
        tbl[7]  = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b01000, 32'h114, 32'h0);
        tbl[8]  = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b01000, 32'h114, 32'h0);
        tbl[9]  = mk(5'b00011, 32'h0, 32'h0,  32'h0, 5'd5,  5'b01000, 32'h114, 32'h0);
        tbl[10] = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b10010, 32'h114, 32'h0);
        tbl[11] = mk(5'b10010, M1,   32'h120, 32'h0, 5'd0,  5'b00010, 32'h0,   32'h0);
        tbl[12] = mk(5'b10000, M2,   32'h124, 32'h0, 5'd0,  5'b01000, 32'h120, 32'h0);
        tbl[13] = mk(5'b10010, M2,   32'h124, 32'h0, 5'd0,  5'b10110, 32'h120, 32'h0);
        tbl[14] = mk(5'b10010, M3,   32'h128, 32'h0, 5'd0,  5'b10110, 32'h124, 32'h0);
        tbl[15] = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b01000, 32'h128, 32'h0);
        tbl[16] = mk(5'b00011, 32'h0, 32'h0,  32'h0, 5'd10, 5'b01000, 32'h128, 32'h0);
        tbl[17] = mk(5'b00010, 32'h0, 32'h0,  32'h0, 5'd0,  5'b10110, 32'h128, 32'h0);
        tbl[18] = mk(5'b00011, 32'h0, 32'h0,  32'h0, 5'd13, 5'b00010, 32'h0,   32'h0);
        tbl[19] = mk(5'b00011, 32'h0, 32'h0,  32'h0, 5'd16, 5'b00010, 32'h0,   32'h0);
        tbl[20] = mk(5'b10010, BEQ,  32'h200, 32'h0,   5'd0, 5'b00010, 32'h0,   32'h0);
        tbl[21] = mk(5'b10110, ADD1, 32'h204, 32'h240, 5'd0, 5'b10000, 32'h200, 32'h0);
        tbl[22] = mk(5'b10010, ADD1, 32'h204, 32'h0,   5'd0, 5'b00011, 32'h0,   32'h240);
        tbl[23] = mk(5'b10010, ADD1, 32'h208, 32'h0,   5'd0, 5'b00010, 32'h0,   32'h240);
        tbl[24] = mk(5'b10010, ADD1, 32'h240, 32'h0,   5'd0, 5'b00010, 32'h0,   32'h240);
        tbl[25] = mk(5'b00010, 32'h0, 32'h0,  32'h0,   5'd0, 5'b10010, 32'h240, 32'h240);
        tbl[26] = mk(5'b00010, 32'h0, 32'h0,  32'h0,   5'd0, 5'b00010, 32'h0,   32'h240);
        tbl[27] = mk(5'b10010, MUL5, 32'h300, 32'h0,   5'd0, 5'b00010, 32'h0,   32'h240);
        tbl[28] = mk(5'b10010, ADD8, 32'h304, 32'h0,   5'd0, 5'b10110, 32'h300, 32'h240);
        tbl[29] = mk(5'b11010, ADD1, 32'h308, 32'h0,   5'd0, 5'b01000, 32'h304, 32'h240);
        tbl[30] = mk(5'b11011, ADD1, 32'h308, 32'h0,   5'd5, 5'b01000, 32'h304, 32'h240);
        tbl[31] = mk(5'b11010, ADD1, 32'h308, 32'h0,   5'd0, 5'b01000, 32'h304, 32'h240);
        tbl[32] = mk(5'b00010, 32'h0, 32'h0,  32'h0,   5'd0, 5'b10010, 32'h304, 32'h240);
        tbl[33] = mk(5'b00010, 32'h0, 32'h0,  32'h0,   5'd0, 5'b00010, 32'h0,   32'h240);

        #3;
        chk(-1, "rst_opcode_valid", {31'd0, opcode_valid_o}, 32'd0);
        chk(-1, "rst_stall", {31'd0, stall_o}, 32'd0);
        chk(-1, "rst_fetch_branch", {31'd0, fetch_branch_o}, 32'd0);
        chk(-1, "rst_branch_pc", fetch_branch_pc_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 34; i++) run_row(tbl[i], i);

        // reset asserted in the middle of a flush with one muldiv op outstanding
        run_row(mk(5'b10010, MUL9, 32'h400, 32'h0,   5'd0, 5'b00010, 32'h0,   32'h240), 100);
        run_row(mk(5'b10010, BEQ,  32'h404, 32'h0,   5'd0, 5'b10110, 32'h400, 32'h240), 101);
        run_row(mk(5'b10110, ADD1, 32'h408, 32'h480, 5'd0, 5'b10000, 32'h404, 32'h240), 102);
        run_row(mk(5'b10010, ADD1, 32'h408, 32'h0,   5'd0, 5'b00011, 32'h0,   32'h480), 103);
        #1;
        rst_i = 1'b1;
        fetch_valid_i = 1'b0;
        #1;
        chk(104, "async_opcode_valid", {31'd0, opcode_valid_o}, 32'd0);
        chk(104, "async_stall", {31'd0, stall_o}, 32'd0);
        chk(104, "async_muldiv_valid", {31'd0, muldiv_valid_o}, 32'd0);
        chk(104, "async_fetch_branch", {31'd0, fetch_branch_o}, 32'd0);
        chk(104, "async_branch_pc", fetch_branch_pc_o, 32'd0);
        chk(104, "async_opcode_pc", opcode_pc_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        // stale completion must not underflow the count: two MULs dispatch, the third waits
        run_row(mk(5'b00011, 32'h0, 32'h0, 32'h0, 5'd9, 5'b00010, 32'h0,   32'h0), 105);
        run_row(mk(5'b10010, MA,  32'h500, 32'h0, 5'd0, 5'b00010, 32'h0,   32'h0), 106);
        run_row(mk(5'b10010, MB,  32'h504, 32'h0, 5'd0, 5'b10110, 32'h500, 32'h0), 107);
        chk(107, "rd_idx", {27'd0, opcode_rd_idx_o}, 32'd20);
        chk(107, "ra_idx", {27'd0, opcode_ra_idx_o}, 32'd21);
        chk(107, "rb_idx", {27'd0, opcode_rb_idx_o}, 32'd22);
        chk(107, "opcode", opcode_opcode_o, MA);
        run_row(mk(5'b10010, MC,  32'h508, 32'h0, 5'd0, 5'b10110, 32'h504, 32'h0), 108);
        run_row(mk(5'b00010, 32'h0, 32'h0, 32'h0, 5'd0, 5'b01000, 32'h508, 32'h0), 109);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
